// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state type and prescale constants for uart_rx_v2
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_STOP2  = 3'd5
  } rx_state_e;

  localparam logic [5:0] PRESCALE_8       = 6'd8;
  localparam logic [5:0] PRESCALE_16      = 6'd16;
  localparam logic [5:0] PRESCALE_32      = 6'd32;
  localparam logic [5:0] PRESCALE_DEFAULT = PRESCALE_16;

  // Any prescale outside the supported set falls back to the default rate.
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    if (p == PRESCALE_8 || p == PRESCALE_16 || p == PRESCALE_32) begin
      return p;
    end
    return PRESCALE_DEFAULT;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive word FIFO, head word presented combinationally
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_rd;
  logic             do_wr;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the head slot, so a write is accepted while full when a pop coincides.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/uart_rx_v2.sv
// rtl/uart_rx_v2.sv - oversampling UART receiver; FIFO output when UART_RX_FIFO_EN is defined
module uart_rx_v2
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic                  stop2,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err,
  output logic                  overrun,
  output logic                  busy
);

  rx_state_e             state_q, state_d;
  logic                  sync1_q, sync2_q, prev_q;
  logic [5:0]            cnt_q, cnt_d;
  logic [3:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [5:0]            pre_q, pre_d;
  logic                  pe_q, pe_d, pt_q, pt_d, s2_q, s2_d;
  logic                  pbit_q, pbit_d, serr_q, serr_d;
  logic                  commit_q, commit_d;
  logic                  s0_q, s1_q;

  logic       rx_s;
  logic [5:0] half, half_m1, half_p1, last;
  logic       vote, at_vote, at_end, perr;

  assign rx_s    = sync2_q;
  assign half    = {1'b0, pre_q[5:1]};
  assign half_m1 = half - 6'd1;
  assign half_p1 = half + 6'd1;
  assign last    = pre_q - 6'd1;
  assign at_vote = (cnt_q == half_p1);
  assign at_end  = (cnt_q == last);
  assign vote    = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign perr    = pe_q & (^shift_q ^ pbit_q ^ pt_q);
  assign busy    = (state_q != ST_IDLE);

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Capture the first two of the three mid-bit samples; the third is live at vote time.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else begin
      if (cnt_q == half_m1) s0_q <= rx_s;
      if (cnt_q == half)    s1_q <= rx_s;
    end
  end

  // Frame state, bit timing and latched per-frame configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      pre_q    <= PRESCALE_DEFAULT;
      pe_q     <= 1'b0;
      pt_q     <= 1'b0;
      s2_q     <= 1'b0;
      pbit_q   <= 1'b0;
      serr_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      pre_q    <= pre_d;
      pe_q     <= pe_d;
      pt_q     <= pt_d;
      s2_q     <= s2_d;
      pbit_q   <= pbit_d;
      serr_q   <= serr_d;
      commit_q <= commit_d;
    end
  end

  // Next-state logic: votes land at mid-bit, bit boundaries at count P-1.
  always_comb begin
    state_d  = state_q;
    cnt_d    = at_end ? 6'd0 : cnt_q + 6'd1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pre_d    = pre_q;
    pe_d     = pe_q;
    pt_d     = pt_q;
    s2_d     = s2_q;
    pbit_d   = pbit_q;
    serr_d   = serr_q;
    commit_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 6'd0;
        if (prev_q && !rx_s) begin
          state_d = ST_START;
          cnt_d   = 6'd1;
          bit_d   = '0;
          pbit_d  = 1'b0;
          serr_d  = 1'b0;
          pre_d   = legal_prescale(prescale);
          pe_d    = par_en;
          pt_d    = par_type;
          s2_d    = stop2;
        end
      end
      ST_START: begin
        if (at_vote && vote) begin
          state_d = ST_IDLE;
          cnt_d   = 6'd0;
        end else if (at_end) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_vote) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
        if (at_end) begin
          if (bit_q == 4'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = pe_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (at_vote) pbit_d = vote;
        if (at_end)  state_d = ST_STOP;
      end
      ST_STOP: begin
        if (at_vote) begin
          serr_d = serr_q | ~vote;
          if (!s2_q) begin
            state_d  = ST_IDLE;
            cnt_d    = 6'd0;
            commit_d = 1'b1;
          end
        end else if (at_end) begin
          state_d = ST_STOP2;
        end
      end
      ST_STOP2: begin
        if (at_vote) begin
          serr_d   = serr_q | ~vote;
          state_d  = ST_IDLE;
          cnt_d    = 6'd0;
          commit_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

`ifdef UART_RX_FIFO_EN
  logic [DATA_WIDTH+1:0] fifo_head;
  logic                  fifo_empty, fifo_full;
  logic                  overrun_q;

  uart_rx_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (commit_q),
    .wr_data_i ({serr_q, perr, shift_q}),
    .rd_en_i   (rd_en),
    .rd_data_o (fifo_head),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign data_valid = !fifo_empty;
  assign {stop_err, par_err, p_data} = fifo_empty ? '0 : fifo_head;
  assign overrun = overrun_q;

  // A commit into a full FIFO is lost unless a pop frees a slot that same cycle.
  always_ff @(posedge clk) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= commit_q && fifo_full && !rd_en;
  end
`else
  logic [DATA_WIDTH-1:0] p_data_q;
  logic                  valid_q, par_err_q, stop_err_q;
  logic                  unused_rd_en;
  logic [31:0]           unused_fifo_depth;

  assign unused_rd_en      = rd_en;
  assign unused_fifo_depth = FIFO_DEPTH;
  assign p_data            = p_data_q;
  assign data_valid        = valid_q;
  assign par_err           = par_err_q;
  assign stop_err          = stop_err_q;
  assign overrun           = 1'b0;

  // Single output register; data_valid is a one-cycle strobe per committed frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      valid_q <= commit_q;
      if (commit_q) begin
        p_data_q   <= shift_q;
        par_err_q  <= perr;
        stop_err_q <= serr_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_v2.sv
// tb/tb_uart_rx_v2.sv - scoreboard bench for uart_rx_v2 (8-bit and 7-bit instances)
module tb_uart_rx_v2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx8, rx7;
  logic [5:0] prescale;
  logic       par_en, par_type, stop2;
  logic       rd8, rd7;
  logic [7:0] pd8;
  logic [6:0] pd7;
  logic       dv8, pe8, se8, ov8, bz8;
  logic       dv7, pe7, se7, ov7, bz7;

  int checks = 0;
  int errors = 0;
  int ovr8 = 0;
  int ovr7 = 0;
  bit rd_auto = 1'b1;
  logic [10:0] q8[$];
  logic [10:0] q7[$];

  always #5 clk = ~clk;

  uart_rx_v2 #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rx_in(rx8), .prescale(prescale), .par_en(par_en),
    .par_type(par_type), .stop2(stop2), .rd_en(rd8), .p_data(pd8),
    .data_valid(dv8), .par_err(pe8), .stop_err(se8), .overrun(ov8), .busy(bz8)
  );

  uart_rx_v2 #(.DATA_WIDTH(7), .FIFO_DEPTH(4)) dut7 (
    .clk(clk), .rst(rst), .rx_in(rx7), .prescale(prescale), .par_en(par_en),
    .par_type(par_type), .stop2(stop2), .rd_en(rd7), .p_data(pd7),
    .data_valid(dv7), .par_err(pe7), .stop_err(se7), .overrun(ov7), .busy(bz7)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_dv8", dv8, 0);   check("rst_pd8", pd8, 0);
    check("rst_pe8", pe8, 0);   check("rst_se8", se8, 0);
    check("rst_ov8", ov8, 0);   check("rst_bz8", bz8, 0);
    check("rst_dv7", dv7, 0);   check("rst_bz7", bz7, 0);
  endtask

  task automatic line(input bit sel7, input bit v, input int n);
    if (sel7) rx7 = v; else rx8 = v;
    repeat (n) @(negedge clk);
  endtask

  // Reference: expected word from what is placed on the wire, {stop_err, par_err, data}.
  task automatic send_frame(input bit sel7, input logic [8:0] d, input logic [5:0] p_cfg,
                            input bit pe, input bit pt, input bit s2, input bit bad_par,
                            input bit st1, input bit st2, input bit expect_word);
    int dw;
    int p;
    logic [8:0] dm;
    bit sent, perr, serr;
    dw   = sel7 ? 7 : 8;
    p    = (p_cfg == 6'd8 || p_cfg == 6'd16 || p_cfg == 6'd32) ? int'(p_cfg) : 16;
    dm   = d & ((9'h1 << dw) - 9'h1);
    sent = (^dm) ^ pt ^ bad_par;
    perr = pe && (((^dm) ^ sent) != pt);
    serr = !st1 || (s2 && !st2);
    if (expect_word) begin
      if (sel7) q7.push_back({serr, perr, dm});
      else      q8.push_back({serr, perr, dm});
    end
    prescale = p_cfg; par_en = pe; par_type = pt; stop2 = s2;
    line(sel7, 1'b0, p);
    prescale = 6'($urandom); par_en = 1'($urandom);
    par_type = 1'($urandom); stop2 = 1'($urandom);
    for (int i = 0; i < dw; i++) line(sel7, d[i], p);
    if (pe) line(sel7, sent, p);
    line(sel7, st1, p);
    if (s2) line(sel7, st2, p);
    line(sel7, 1'b1, 4 + int'($urandom_range(0, p)));
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((q8.size() != 0 || q7.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q8.size() != 0 || q7.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d words outstanding, expected 0", q8.size(), q7.size());
    end
  endtask

  // Monitor for the 8-bit instance.
  initial begin
    logic [10:0] e;
    logic last8;
    last8 = 1'b0;
    rd8 = 1'b0;
    forever begin
      @(negedge clk);
      rd8 = 1'b0;
      if (ov8) ovr8++;
`ifndef UART_RX_FIFO_EN
      if (last8) check("dut8_valid_pulse", dv8, 0);
`endif
      last8 = dv8;
      if (dv8 && !rst && rd_auto) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut8_unexpected: got word 0x%0h, none expected", pd8);
        end else begin
          e = q8.pop_front();
          check("dut8_data", pd8, e[7:0]);
          check("dut8_par_err", pe8, e[9]);
          check("dut8_stop_err", se8, e[10]);
        end
`ifdef UART_RX_FIFO_EN
        rd8 = 1'b1;
`endif
      end
    end
  end

  // Monitor for the 7-bit instance.
  initial begin
    logic [10:0] e;
    logic last7;
    last7 = 1'b0;
    rd7 = 1'b0;
    forever begin
      @(negedge clk);
      rd7 = 1'b0;
      if (ov7) ovr7++;
`ifndef UART_RX_FIFO_EN
      if (last7) check("dut7_valid_pulse", dv7, 0);
`endif
      last7 = dv7;
      if (dv7 && !rst && rd_auto) begin
        if (q7.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut7_unexpected: got word 0x%0h, none expected", pd7);
        end else begin
          e = q7.pop_front();
          check("dut7_data", pd7, e[6:0]);
          check("dut7_par_err", pe7, e[9]);
          check("dut7_stop_err", se7, e[10]);
        end
`ifdef UART_RX_FIFO_EN
        rd7 = 1'b1;
`endif
      end
    end
  end

  initial begin
    int ps[3];
    logic [8:0] ds[3];
    int base;
    int idx;
    ps = '{8, 16, 32};
    ds = '{9'h00, 9'hA5, 9'hFF};
    rst = 1'b1; rx8 = 1'b1; rx7 = 1'b1;
    prescale = 6'd16; par_en = 1'b0; par_type = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        send_frame(0, ds[j], 6'(ps[i]), 0, 0, 0, 0, 1, 1, 1);
    wait_drain(200);

    send_frame(1, 9'h55, 6'd16, 1, 1, 0, 1, 1, 1, 1);
    send_frame(1, 9'h55, 6'd16, 1, 1, 0, 0, 1, 1, 1);
    send_frame(0, 9'h3C, 6'd16, 0, 0, 1, 0, 1, 0, 1);
    send_frame(0, 9'h5A, 6'd12, 1, 0, 0, 0, 1, 1, 1);
    wait_drain(200);

    prescale = 6'd16;
    rx8 = 1'b0;
    repeat (2) @(negedge clk);
    rx8 = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_busy_seen", bz8, 1);
    repeat (30) @(negedge clk);
    check("glitch_busy_cleared", bz8, 0);

    for (int k = 0; k < 40; k++) begin
      idx = int'($urandom_range(0, 3));
      send_frame(1'($urandom), 9'($urandom), (idx < 3) ? 6'(ps[idx]) : 6'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 7) != 0, $urandom_range(0, 7) != 0, 1);
    end
    wait_drain(500);

    prescale = 6'd16; par_en = 1'b0; stop2 = 1'b0;
    line(0, 1'b0, 16);
    line(0, 1'b1, 16);
    line(0, 1'b0, 16);
    check("busy_mid_data", bz8, 1);
    rst = 1'b1; rx8 = 1'b1;
    q8.delete(); q7.delete();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    check("busy_after_rst", bz8, 0);
    send_frame(0, 9'h81, 6'd16, 0, 0, 0, 0, 1, 1, 1);
    wait_drain(200);

`ifdef UART_RX_FIFO_EN
    rd_auto = 1'b0;
    repeat (2) @(negedge clk);
    base = ovr8;
    for (int i = 0; i < 5; i++)
      send_frame(0, 9'(8'h10 + i), 6'd16, 0, 0, 0, 0, 1, 1, i < 4);
    check("fifo_overrun_pulses", ovr8 - base, 1);
    check("fifo_full_valid", dv8, 1);
    rd_auto = 1'b1;
    wait_drain(100);
    repeat (3) @(negedge clk);
    check("fifo_empty_after_drain", dv8, 0);
`else
    base = 0;
    check("no_fifo_overrun", ovr8 + ovr7, base);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
